// File: rtl/frac_ramp_ctrl.sv
// frac_ramp_ctrl: accepts clamped signed targets and ramps the modulator word toward
// them in bounded steps, then dwells before flagging settled. Optional: FRAC_DITHER_EN.
module frac_ramp_ctrl #(
  parameter int WIDTH      = 9,
  parameter int STEP_W     = 6,
  parameter int DIV_W      = 8,
  parameter int LIMIT_POS  = 127,
  parameter int LIMIT_NEG  = -128,
  parameter int SETTLE_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              abort,
  input  logic [WIDTH-1:0]  tgt_word,
  input  logic [STEP_W-1:0] tgt_step,
  input  logic [DIV_W-1:0]  tgt_div,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  output logic [WIDTH-1:0]  dsm_word,
  output logic              busy,
  output logic              settled
);

  localparam int DWELL_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [DWELL_W-1:0]      DWELL_LAST = DWELL_W'(SETTLE_CYC - 1);
  localparam logic signed [WIDTH-1:0] LIM_P      = WIDTH'(LIMIT_POS);
  localparam logic signed [WIDTH-1:0] LIM_N      = WIDTH'(LIMIT_NEG);

  typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_SETTLE} state_t;

  state_t                    r_state;
  logic signed [WIDTH-1:0]   r_word;
  logic signed [WIDTH-1:0]   r_tgt;
  logic [STEP_W-1:0]         r_step;
  logic [DIV_W-1:0]          r_div;
  logic [DIV_W-1:0]          r_tick;
  logic [DWELL_W-1:0]        r_dwell;
  logic                      r_busy;
  logic                      r_settled;

  logic                      w_accept;
  logic signed [WIDTH-1:0]   w_tgt_in;
  logic signed [WIDTH-1:0]   w_clamp;
  logic [STEP_W-1:0]         w_step_in;
  logic [WIDTH:0]            w_diff;
  logic [WIDTH:0]            w_adiff;
  logic                      w_last_step;
  logic [WIDTH-1:0]          w_step_w;

  assign tgt_ready = (r_state == ST_IDLE) && enable && !abort;
  assign w_accept  = tgt_valid && tgt_ready;
  assign busy      = r_busy;
  assign settled   = r_settled;

  always_comb begin
    w_tgt_in = $signed(tgt_word);
    if (w_tgt_in > LIM_P)
      w_clamp = LIM_P;
    else if (w_tgt_in < LIM_N)
      w_clamp = LIM_N;
    else
      w_clamp = w_tgt_in;
  end

  assign w_step_in = (tgt_step == '0) ? STEP_W'(1) : tgt_step;

  // Distance is taken one bit wider so the full signed span never wraps.
  assign w_diff      = {r_tgt[WIDTH-1], r_tgt} - {r_word[WIDTH-1], r_word};
  assign w_adiff     = w_diff[WIDTH] ? (~w_diff + (WIDTH+1)'(1)) : w_diff;
  assign w_last_step = (w_adiff <= (WIDTH+1)'(r_step));
  assign w_step_w    = WIDTH'(r_step);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_word    <= '0;
      r_tgt     <= '0;
      r_step    <= '0;
      r_div     <= '0;
      r_tick    <= '0;
      r_dwell   <= '0;
      r_busy    <= 1'b0;
      r_settled <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tgt     <= w_clamp;
            r_step    <= w_step_in;
            r_div     <= tgt_div;
            r_tick    <= '0;
            r_dwell   <= '0;
            r_settled <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= (w_clamp == r_word) ? ST_SETTLE : ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (abort) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_settled <= 1'b0;
          end else if (enable) begin
            if (r_tick == r_div) begin
              r_tick <= '0;
              if (w_last_step) begin
                r_word  <= r_tgt;
                r_dwell <= '0;
                r_state <= ST_SETTLE;
              end else if (w_diff[WIDTH]) begin
                r_word <= r_word - w_step_w;
              end else begin
                r_word <= r_word + w_step_w;
              end
            end else begin
              r_tick <= r_tick + DIV_W'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_settled <= 1'b0;
          end else if (enable) begin
            if (r_dwell == DWELL_LAST) begin
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_settled <= 1'b1;
            end else begin
              r_dwell <= r_dwell + DWELL_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FRAC_DITHER_EN
  logic [14:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst)
      r_lfsr <= 15'd1;
    else
      r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
  end

  // Dither only once parked and settled; saturate so the upper clamp is never exceeded.
  always_comb begin
    dsm_word = r_word;
    if ((r_state == ST_IDLE) && r_settled && r_lfsr[0] && (r_word != LIM_P))
      dsm_word = r_word + WIDTH'(1);
  end
`else
  assign dsm_word = r_word;
`endif

endmodule

// File: tb/tb_frac_ramp_ctrl.sv
// Scoreboard bench for frac_ramp_ctrl: a reference model predicts word-change and
// settled-rise events per accepted target; a monitor pops and compares them.
module tb_frac_ramp_ctrl;

  localparam int W  = 9;
  localparam int SW = 6;
  localparam int DW = 8;
  localparam int SC = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  tgt_word = '0;
  logic [SW-1:0] tgt_step = '0;
  logic [DW-1:0] tgt_div = '0;
  logic          tgt_valid = 1'b0;
  logic          tgt_ready;
  logic [W-1:0]  dsm_word;
  logic          busy;
  logic          settled;

  frac_ramp_ctrl #(
    .WIDTH(W), .STEP_W(SW), .DIV_W(DW),
    .LIMIT_POS(127), .LIMIT_NEG(-128), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .abort(abort),
    .tgt_word(tgt_word), .tgt_step(tgt_step), .tgt_div(tgt_div),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .dsm_word(dsm_word), .busy(busy), .settled(settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_set;
    int edge_no;
    int val;
  } ev_t;

  ev_t  sbq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_word = 0;
  bit   mon_en = 1'b0;
  logic [W-1:0] prev_word = '0;
  logic prev_settled = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sw2i(logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clampi(int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic chk(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: walk the target in whole steps using enabled-cycle offsets, then map
  // offsets to real edges around an optional freeze window and drop anything at or
  // after an abort edge.
  function automatic void plan(int t_raw, int s_raw, int d, int a, int f, int l, int x);
    int t;
    int s;
    int w;
    int o;
    int lim;
    ev_t e;
    t = clampi(t_raw);
    s = (s_raw == 0) ? 1 : s_raw;
    w = m_word;
    o = 0;
    lim = (x > 0) ? a + x : 32'h7fffffff;
    while (w != t) begin
      o += d + 1;
      if ((t - w <= s) && (w - t <= s)) w = t;
      else if (t > w) w += s;
      else w -= s;
      e.is_set = 1'b0;
      e.edge_no = a + o + ((o > f) ? l : 0);
      e.val = w;
      if (e.edge_no < lim) begin
        sbq.push_back(e);
        m_word = w;
      end
    end
    o += SC;
    e.is_set = 1'b1;
    e.edge_no = a + o + ((o > f) ? l : 0);
    e.val = t;
    if (e.edge_no < lim) sbq.push_back(e);
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (dsm_word !== prev_word) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %0d at cycle %0d, expected no change", sw2i(dsm_word), cyc);
        end else begin
          e = sbq.pop_front();
          if (e.is_set || e.edge_no != cyc || e.val != sw2i(dsm_word)) begin
            n_fail++;
            $display("FAIL word_event: got word %0d at cycle %0d, expected %s %0d at cycle %0d",
                     sw2i(dsm_word), cyc, e.is_set ? "settled" : "word", e.val, e.edge_no);
          end
        end
      end
      if (settled && !prev_settled) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_settled: got rise at cycle %0d, expected none", cyc);
        end else begin
          e = sbq.pop_front();
          if (!e.is_set || e.edge_no != cyc) begin
            n_fail++;
            $display("FAIL settled_event: got rise at cycle %0d, expected %s at cycle %0d",
                     cyc, e.is_set ? "settled" : "word", e.edge_no);
          end
        end
      end
    end
    prev_word = dsm_word;
    prev_settled = settled;
  end

  task automatic do_txn(int t, int s, int d, int f, int l, int x, bit hold);
    int a;
    int r;
    int budget;
    @(negedge clk); #1;
    tgt_word = W'(t); tgt_step = SW'(s); tgt_div = DW'(d);
    tgt_valid = 1'b1; enable = 1'b1; abort = 1'b0;
    #1;
    budget = 0;
    while (!tgt_ready && budget < 50) begin
      @(negedge clk); #2;
      budget++;
    end
    if (!tgt_ready) begin
      chk("accept_timeout", 0, 1);
      tgt_valid = 1'b0;
      return;
    end
    a = cyc + 1;
    plan(t, s, d, a, f, l, x);
    budget = 0;
    forever begin
      @(negedge clk); #1;
      r = cyc - a;
      if (x > 0 && r == x) break;
      if (x == 0 && sbq.size() == 0) break;
      if (budget++ > 4000) begin
        chk("ramp_timeout", sbq.size(), 0);
        sbq.delete();
        break;
      end
      tgt_valid = hold;
      if (hold) tgt_word = W'($urandom_range(0, 511));
      enable = !((r + 1 > f) && (r + 1 <= f + l));
      abort = (x > 0) && (r + 1 == x);
      #1;
      if (enable && !abort && hold) chk("ready_low_busy", int'(tgt_ready), 0);
    end
    tgt_valid = 1'b0; enable = 1'b1; abort = 1'b0;
    #1;
    chk("busy_end", int'(busy), 0);
    chk("ready_end", int'(tgt_ready), 1);
    chk("settled_end", int'(settled), (x > 0) ? 0 : 1);
    chk("word_end", sw2i(dsm_word), m_word);
    if (x > 0) chk("abort_queue_empty", sbq.size(), 0);
  endtask

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int t;
    int f;
    int l;
    int x;
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_word", sw2i(dsm_word), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_settled", int'(settled), 0);
    chk("reset_ready", int'(tgt_ready), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    do_txn(40, 8, 0, 0, 0, 0, 1'b1);
    do_txn(-20, 25, 3, 0, 0, 0, 1'b0);
    do_txn(255, 63, 1, 0, 0, 0, 1'b0);
    do_txn(-256, 63, 0, 0, 0, 0, 1'b0);
    do_txn(100, 10, 2, 7, 10, 0, 1'b0);
    do_txn(-100, 5, 1, 0, 0, 9, 1'b0);
    do_txn(m_word, 0, 0, 0, 0, 0, 1'b1);
    do_txn(m_word + 3, 5, 0, 0, 0, 20, 1'b0);

    for (int i = 0; i < 14; i++) begin
      t = sw2i(W'($urandom_range(0, 511)));
      f = 0; l = 0; x = 0;
      if ($urandom_range(0, 2) == 0) begin
        f = $urandom_range(1, 6);
        l = $urandom_range(1, 8);
      end
      if ($urandom_range(0, 3) == 0) x = $urandom_range(2, 30);
      do_txn(t, $urandom_range(0, 63), $urandom_range(0, 4), f, l, x, 1'($urandom_range(0, 1)));
    end

    mon_en = 1'b0;
    @(negedge clk); #1;
    tgt_word = W'((m_word > 0) ? -100 : 100);
    tgt_step = SW'(1); tgt_div = '0; tgt_valid = 1'b1; enable = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    tgt_valid = 1'b0;
    chk("midramp_busy", int'(busy), 1);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk); #1;
    chk("midramp_reset_word", sw2i(dsm_word), 0);
    chk("midramp_reset_busy", int'(busy), 0);
    chk("midramp_reset_ready", int'(tgt_ready), 0);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_word", sw2i(dsm_word), 0);
    chk("post_reset_settled", int'(settled), 0);
    chk("post_reset_ready", int'(tgt_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
